// File: rtl/m2_block_scheduler.sv
// Purpose : sequences the M2 IDCT datapath over Y, U, V 8x8 blocks, overlapping fetch of k+1 with compute/write of k.
// Latency : m2_start -> first fetch_start next cycle; the later of the two dones -> next start pair next cycle.
// Backpress: none on outputs; the engines pace the walk through their done pulses, which are held in sticky flags.
//
// Ports:
//   CLOCK_50_I, resetn             clock, asynchronous active-low reset
//   m2_start                       one-cycle pulse that starts a full-image pass (ignored while busy)
//   fetch_start/base/stride/buf    fetch request for the next S' block into a ping-pong buffer
//   fetch_done                     fetch engine completion pulse
//   cw_start/base/stride/buf       compute/write request for the block just fetched
//   cw_done                        compute/write engine completion pulse
//   block_idx                      index of the block in compute/write (0..2399)
//   busy, m2_end                   pass in progress / one-cycle pass-complete pulse
module m2_block_scheduler #(
    parameter logic [17:0] Y_READ_BASE  = 18'd76800,
    parameter logic [17:0] U_READ_BASE  = 18'd153600,
    parameter logic [17:0] V_READ_BASE  = 18'd192000,
    parameter logic [17:0] Y_WRITE_BASE = 18'd0,
    parameter logic [17:0] U_WRITE_BASE = 18'd38400,
    parameter logic [17:0] V_WRITE_BASE = 18'd57600
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        m2_start,
    output logic        fetch_start,
    output logic [17:0] fetch_base,
    output logic [8:0]  fetch_stride,
    output logic        fetch_buf,
    input  logic        fetch_done,
    output logic        cw_start,
    output logic [17:0] cw_base,
    output logic [7:0]  cw_stride,
    output logic        cw_buf,
    input  logic        cw_done,
    output logic [11:0] block_idx,
    output logic        busy,
    output logic        m2_end
);

    localparam logic [11:0] LAST_BLK = 12'd2399;
    localparam logic [4:0]  LAST_ROW = 5'd29;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_IN, S_WAIT_F, S_ISSUE, S_WAIT_BOTH, S_WAIT_C, S_FINISH
    } state_t;

    typedef enum logic [1:0] {SEG_Y, SEG_U, SEG_V} seg_t;

    state_t      state;

    // Fetch walker: position of the block currently held on the fetch outputs.
    // fetch_base doubles as its read address; f_wr is the matching write address.
    seg_t        f_seg;
    logic [5:0]  f_col;
    logic [4:0]  f_row;
    logic [17:0] f_rd_row;      // read address of column 0 in the current block row
    logic [17:0] f_wr_row;      // write address of column 0 in the current block row
    logic [17:0] f_wr;
    logic [11:0] f_idx;

    logic        f_flag;
    logic        c_flag;

    // Next fetch walker position, built by incremental adds only.
    seg_t        nx_seg;
    logic [5:0]  nx_col;
    logic [4:0]  nx_row;
    logic [17:0] nx_rd_row;
    logic [17:0] nx_wr_row;
    logic [17:0] nx_rd;
    logic [17:0] nx_wr;
    logic [5:0]  last_col;
    logic        issue;

    always_comb begin
        last_col  = (f_seg == SEG_Y) ? 6'd39 : 6'd19;
        nx_seg    = f_seg;
        nx_col    = f_col;
        nx_row    = f_row;
        nx_rd_row = f_rd_row;
        nx_wr_row = f_wr_row;
        nx_rd     = fetch_base;
        nx_wr     = f_wr;
        if (f_col != last_col) begin
            nx_col = f_col + 6'd1;
            nx_rd  = fetch_base + 18'd8;
            nx_wr  = f_wr + 18'd4;
        end else if (f_row != LAST_ROW) begin
            nx_col    = 6'd0;
            nx_row    = f_row + 5'd1;
            // 8 rows of S' (320 or 160 words) and 8 rows of output (160 or 80 words)
            nx_rd_row = f_rd_row + ((f_seg == SEG_Y) ? 18'd2560 : 18'd1280);
            nx_wr_row = f_wr_row + ((f_seg == SEG_Y) ? 18'd1280 : 18'd640);
            nx_rd     = nx_rd_row;
            nx_wr     = nx_wr_row;
        end else begin
            nx_col = 6'd0;
            nx_row = 5'd0;
            if (f_seg == SEG_Y) begin
                nx_seg    = SEG_U;
                nx_rd_row = U_READ_BASE;
                nx_wr_row = U_WRITE_BASE;
            end else begin
                nx_seg    = SEG_V;
                nx_rd_row = V_READ_BASE;
                nx_wr_row = V_WRITE_BASE;
            end
            nx_rd = nx_rd_row;
            nx_wr = nx_wr_row;
        end
    end

    // Hand-over point: the block just fetched moves to compute/write.
    // Current done inputs are ORed with the sticky flags so the later
    // done produces start pulses on the very next cycle.
    assign issue = ((state == S_WAIT_F) && fetch_done) ||
                   ((state == S_WAIT_BOTH) && (f_flag || fetch_done) && (c_flag || cw_done));

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            fetch_start  <= 1'b0;
            fetch_base   <= Y_READ_BASE;
            fetch_stride <= 9'd320;
            fetch_buf    <= 1'b0;
            cw_start     <= 1'b0;
            cw_base      <= 18'd0;
            cw_stride    <= 8'd160;
            cw_buf       <= 1'b0;
            block_idx    <= 12'd0;
            busy         <= 1'b0;
            m2_end       <= 1'b0;
            f_seg        <= SEG_Y;
            f_col        <= 6'd0;
            f_row        <= 5'd0;
            f_rd_row     <= Y_READ_BASE;
            f_wr_row     <= Y_WRITE_BASE;
            f_wr         <= Y_WRITE_BASE;
            f_idx        <= 12'd0;
            f_flag       <= 1'b0;
            c_flag       <= 1'b0;
        end else begin
            fetch_start <= 1'b0;
            cw_start    <= 1'b0;
            m2_end      <= 1'b0;

            case (state)
                S_IDLE: begin
                    // The block-0 fetch pulse is registered here so it is
                    // visible during LEAD_IN, one cycle after m2_start.
                    if (m2_start) begin
                        busy         <= 1'b1;
                        fetch_start  <= 1'b1;
                        fetch_base   <= Y_READ_BASE;
                        fetch_stride <= 9'd320;
                        fetch_buf    <= 1'b0;
                        f_seg        <= SEG_Y;
                        f_col        <= 6'd0;
                        f_row        <= 5'd0;
                        f_rd_row     <= Y_READ_BASE;
                        f_wr_row     <= Y_WRITE_BASE;
                        f_wr         <= Y_WRITE_BASE;
                        f_idx        <= 12'd0;
                        f_flag       <= 1'b0;
                        c_flag       <= 1'b0;
                        state        <= S_LEAD_IN;
                    end
                end
                S_LEAD_IN: state <= S_WAIT_F;
                S_WAIT_F: begin
                    if (fetch_done) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    f_flag <= 1'b0;
                    c_flag <= 1'b0;
                    state  <= (block_idx == LAST_BLK) ? S_WAIT_C : S_WAIT_BOTH;
                end
                S_WAIT_BOTH: begin
                    if (issue) begin
                        f_flag <= 1'b0;
                        c_flag <= 1'b0;
                        state  <= S_ISSUE;
                    end else begin
                        f_flag <= f_flag | fetch_done;
                        c_flag <= c_flag | cw_done;
                    end
                end
                S_WAIT_C: begin
                    if (cw_done) begin
                        m2_end <= 1'b1;
                        state  <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                cw_start  <= 1'b1;
                cw_base   <= f_wr;
                cw_stride <= (f_seg == SEG_Y) ? 8'd160 : 8'd80;
                cw_buf    <= fetch_buf;
                block_idx <= f_idx;
                // The final block has nothing behind it to prefetch.
                if (f_idx != LAST_BLK) begin
                    fetch_start  <= 1'b1;
                    fetch_buf    <= ~fetch_buf;
                    fetch_base   <= nx_rd;
                    fetch_stride <= (nx_seg == SEG_Y) ? 9'd320 : 9'd160;
                    f_seg        <= nx_seg;
                    f_col        <= nx_col;
                    f_row        <= nx_row;
                    f_rd_row     <= nx_rd_row;
                    f_wr_row     <= nx_wr_row;
                    f_wr         <= nx_wr;
                    f_idx        <= f_idx + 12'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Purpose : scoreboard bench for m2_block_scheduler; stimulus queues expected start/end pulses, a monitor pops and checks them.
// Latency : expected pulses carry the exact cycle they must appear in.
// Backpress: the bench plays both engines, returning done pulses in varied orders.
module tb_m2_block_scheduler;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn;
    logic        m2_start;
    logic        fetch_start;
    logic [17:0] fetch_base;
    logic [8:0]  fetch_stride;
    logic        fetch_buf;
    logic        fetch_done;
    logic        cw_start;
    logic [17:0] cw_base;
    logic [7:0]  cw_stride;
    logic        cw_buf;
    logic        cw_done;
    logic [11:0] block_idx;
    logic        busy;
    logic        m2_end;

    m2_block_scheduler dut (
        .CLOCK_50_I   (CLOCK_50_I),
        .resetn       (resetn),
        .m2_start     (m2_start),
        .fetch_start  (fetch_start),
        .fetch_base   (fetch_base),
        .fetch_stride (fetch_stride),
        .fetch_buf    (fetch_buf),
        .fetch_done   (fetch_done),
        .cw_start     (cw_start),
        .cw_base      (cw_base),
        .cw_stride    (cw_stride),
        .cw_buf       (cw_buf),
        .cw_done      (cw_done),
        .block_idx    (block_idx),
        .busy         (busy),
        .m2_end       (m2_end)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    int cyc = 0;
    always @(posedge CLOCK_50_I) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int k;
    } exp_t;

    exp_t fq[$];
    exp_t cq[$];
    int   eq[$];

    int n_total = 0;
    int n_bad   = 0;
    int n_fs    = 0;
    int n_cs    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50_I);
        #1;
    endtask

    task automatic clr();
        fetch_done = 1'b0;
        cw_done    = 1'b0;
        m2_start   = 1'b0;
    endtask

    // Reference addresses from the row/column formula.
    function automatic void model(input int k, output int rd, output int wr,
                                  output int rs, output int ws);
        int j, r, c;
        if (k < 1200) begin
            r = k / 40; c = k % 40;
            rd = 76800 + r * 2560 + c * 8;
            wr = r * 1280 + c * 4;
            rs = 320; ws = 160;
        end else begin
            j = (k < 1800) ? k - 1200 : k - 1800;
            r = j / 20; c = j % 20;
            rd = ((k < 1800) ? 153600 : 192000) + r * 1280 + c * 8;
            wr = ((k < 1800) ? 38400 : 57600) + r * 640 + c * 4;
            rs = 160; ws = 80;
        end
    endfunction

    // Hand-computed addresses at segment corners and walk checkpoints.
    function automatic bit hand(input int k, output int rd, output int wr);
        rd = 0; wr = 0;
        case (k)
            0:    begin rd = 76800;  wr = 0;     return 1'b1; end
            1:    begin rd = 76808;  wr = 4;     return 1'b1; end
            41:   begin rd = 79368;  wr = 1284;  return 1'b1; end
            1199: begin rd = 151352; wr = 37276; return 1'b1; end
            1200: begin rd = 153600; wr = 38400; return 1'b1; end
            1800: begin rd = 192000; wr = 57600; return 1'b1; end
            2399: begin rd = 229272; wr = 76236; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    exp_t m_e;
    int   m_rd, m_wr, m_rs, m_ws, m_hr, m_hw, m_ec;

    always @(negedge CLOCK_50_I) begin
        if (fetch_start) begin
            n_fs++;
            if (fq.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL fetch_unexpected: fetch_start at cycle %0d, none pending", cyc);
            end else begin
                m_e = fq.pop_front();
                model(m_e.k, m_rd, m_wr, m_rs, m_ws);
                check($sformatf("fetch_cycle k=%0d", m_e.k), cyc, m_e.cyc);
                check($sformatf("fetch_base k=%0d", m_e.k), int'(fetch_base), m_rd);
                check($sformatf("fetch_stride k=%0d", m_e.k), int'(fetch_stride), m_rs);
                check($sformatf("fetch_buf k=%0d", m_e.k), int'(fetch_buf), m_e.k % 2);
                if (hand(m_e.k, m_hr, m_hw))
                    check($sformatf("fetch_base_hand k=%0d", m_e.k), int'(fetch_base), m_hr);
            end
        end
        if (cw_start) begin
            n_cs++;
            if (cq.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL cw_unexpected: cw_start at cycle %0d, none pending", cyc);
            end else begin
                m_e = cq.pop_front();
                model(m_e.k, m_rd, m_wr, m_rs, m_ws);
                check($sformatf("cw_cycle k=%0d", m_e.k), cyc, m_e.cyc);
                check($sformatf("cw_base k=%0d", m_e.k), int'(cw_base), m_wr);
                check($sformatf("cw_stride k=%0d", m_e.k), int'(cw_stride), m_ws);
                check($sformatf("cw_buf k=%0d", m_e.k), int'(cw_buf), m_e.k % 2);
                check($sformatf("block_idx k=%0d", m_e.k), int'(block_idx), m_e.k);
                if (hand(m_e.k, m_hr, m_hw))
                    check($sformatf("cw_base_hand k=%0d", m_e.k), int'(cw_base), m_hw);
            end
        end
        if (m2_end) begin
            if (eq.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL end_unexpected: m2_end at cycle %0d, none pending", cyc);
            end else begin
                m_ec = eq.pop_front();
                check("m2_end_cycle", cyc, m_ec);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_fetch_start"},  int'(fetch_start), 0);
        check({tag, "_cw_start"},     int'(cw_start), 0);
        check({tag, "_busy"},         int'(busy), 0);
        check({tag, "_m2_end"},       int'(m2_end), 0);
        check({tag, "_fetch_base"},   int'(fetch_base), 76800);
        check({tag, "_cw_base"},      int'(cw_base), 0);
        check({tag, "_fetch_stride"}, int'(fetch_stride), 320);
        check({tag, "_cw_stride"},    int'(cw_stride), 160);
        check({tag, "_fetch_buf"},    int'(fetch_buf), 0);
        check({tag, "_cw_buf"},       int'(cw_buf), 0);
        check({tag, "_block_idx"},    int'(block_idx), 0);
    endtask

    // Drive fetch_done in relative cycle df and cw_done in dc (1 = first cycle);
    // l returns the cycle in which the later done was driven.
    task automatic drive(input int df, input int dc, input bit st, output int l);
        int n;
        n = (df > dc) ? df : dc;
        for (int i = 1; i <= n; i++) begin
            tick();
            fetch_done = (i == df);
            cw_done    = (i == dc);
            m2_start   = st && (i == 1);
        end
        l = cyc;
    endtask

    // Runs a pass; returns right after cw_start of block 'stop' (stop<0: full pass).
    task automatic run_pass(input int stop, input int mid_k);
        int l;
        tick();
        m2_start = 1'b1;
        fq.push_back(exp_t'{cyc + 1, 0});
        tick();
        m2_start = 1'b0;
        check("busy_rise", int'(busy), 1);
        // Stray cw_done while waiting for the first fetch must be ignored.
        drive(3, 1, 1'b0, l);
        cq.push_back(exp_t'{l + 1, 0});
        fq.push_back(exp_t'{l + 1, 1});
        tick();
        clr();
        for (int k = 0; k < 2400; k++) begin
            if (k == stop) return;
            if (k == 2399) begin
                drive(1, 2, 1'b0, l);
                eq.push_back(l + 1);
                tick();
                clr();
                m2_start = 1'b1;           // lands in the m2_end cycle: ignored
                check("busy_during_end", int'(busy), 1);
                tick();
                check("busy_fall", int'(busy), 0);
                check("cw_start_total", n_cs, 2400);
                check("fetch_start_total", n_fs, 2400);
                fq.push_back(exp_t'{cyc + 1, 0});  // accepted two cycles after final cw_done
                tick();
                m2_start = 1'b0;
                check("busy_restart", int'(busy), 1);
            end else begin
                case (k % 3)
                    0:       drive(3, 1, k == mid_k, l);   // cw_done first
                    1:       drive(1, 2, k == mid_k, l);   // fetch_done first
                    default: drive(2, 2, k == mid_k, l);   // same cycle
                endcase
                cq.push_back(exp_t'{l + 1, k + 1});
                if (k + 2 <= 2399) fq.push_back(exp_t'{l + 1, k + 2});
                tick();
                clr();
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        m2_start   = 1'b0;
        fetch_done = 1'b0;
        cw_done    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            m2_start   = i[0];
            fetch_done = ~i[0];
            cw_done    = (i % 3 == 0);
        end
        tick();
        clr();
        check_reset("rst_hold");
        resetn = 1'b1;
        tick();
        tick();
        check_reset("rst_idle");

        run_pass(500, 100);
        tick();
        resetn = 1'b0;
        #1;
        check_reset("rst_mid");
        check("rst_mid_fetch_pending", fq.size(), 0);
        check("rst_mid_cw_pending", cq.size(), 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        n_fs = 0;
        n_cs = 0;

        run_pass(-1, -1);
        tick();
        tick();
        check("end_fetch_pending", fq.size(), 0);
        check("end_cw_pending", cq.size(), 0);
        check("end_m2_end_pending", eq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
